sap_controlador_sequenciador: RTL and testbench

Control/sequencer unit for the SAP-1 datapath. It runs a 6-state T-state ring counter and decodes the opcode nibble held in the instruction register (its upper 4 bits). Each cycle it drives the control word that sequences the PC, MAR, RAM, instruction register, accumulator A, register B, ALU and output register. It owns fetch (T1–T3), execute (T4–T6) and halt.

---
 rtl/sap_pkg.sv | 40 ++++
 rtl/sap_contador_anel_6.sv | 33 +++
 rtl/sap_controlador_sequenciador.sv | 136 +++++++++++++
 tb/tb_sap_controlador_sequenciador.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// Shared constants and types for the SAP-1 control/sequencer unit.
// Opcodes, one-hot T-state codes, control-word bit positions and the sequencer state enum.
package sap_pkg;

    localparam logic [3:0] OPC_LDA = 4'b0000;
    localparam logic [3:0] OPC_ADD = 4'b0001;
    localparam logic [3:0] OPC_SUB = 4'b0010;
    localparam logic [3:0] OPC_OUT = 4'b1110;
    localparam logic [3:0] OPC_HLT = 4'b1111;

    localparam logic [5:0] TS_T1 = 6'b000001;
    localparam logic [5:0] TS_T2 = 6'b000010;
    localparam logic [5:0] TS_T3 = 6'b000100;
    localparam logic [5:0] TS_T4 = 6'b001000;
    localparam logic [5:0] TS_T5 = 6'b010000;
    localparam logic [5:0] TS_T6 = 6'b100000;

    localparam int unsigned CW_PC_INC  = 0;
    localparam int unsigned CW_PC_OUT  = 1;
    localparam int unsigned CW_MAR_IN  = 2;
    localparam int unsigned CW_RAM_OUT = 3;
    localparam int unsigned CW_IR_IN   = 4;
    localparam int unsigned CW_IR_OUT  = 5;
    localparam int unsigned CW_A_IN    = 6;
    localparam int unsigned CW_A_OUT   = 7;
    localparam int unsigned CW_B_IN    = 8;
    localparam int unsigned CW_ALU_OUT = 9;
    localparam int unsigned CW_SUB     = 10;
    localparam int unsigned CW_OUT_IN  = 11;
    localparam int unsigned CW_HLT     = 12;
    localparam int unsigned CW_WIDTH   = 13;

    typedef logic [CW_WIDTH-1:0] ctrl_word_t;

    typedef enum logic {
        StRun,
        StHalted
    } sap_state_e;

endpackage

// File: rtl/sap_contador_anel_6.sv
// Six-state one-hot ring counter with async active-low clear, advance enable and load-to-T1.
module sap_contador_anel_6
    import sap_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       advance_i,
    input  logic       load_t1_i,
    output logic [5:0] ring_o
);

    logic [5:0] ring_q, ring_d;

    always_comb begin
        ring_d = ring_q;
        if (load_t1_i) begin
            ring_d = TS_T1;
        end else if (advance_i) begin
            ring_d = {ring_q[4:0], ring_q[5]};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ring_q <= TS_T1;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign ring_o = ring_q;

endmodule

// File: rtl/sap_controlador_sequenciador.sv
// SAP-1 control/sequencer: T-state ring plus opcode decode into the datapath control word.
// Define SAP_CTRL_CICLO_CURTO_EN to return to T1 right after an instruction's last active state.
module sap_controlador_sequenciador
    import sap_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] opcode,
    output logic [5:0] t_state,
    output logic       PC_INC,
    output logic       PC_OUT,
    output logic       MAR_IN,
    output logic       RAM_OUT,
    output logic       IR_IN,
    output logic       IR_OUT,
    output logic       A_IN,
    output logic       A_OUT,
    output logic       B_IN,
    output logic       ALU_OUT,
    output logic       SUB,
    output logic       OUT_IN,
    output logic       HLT
);

    sap_state_e state_q, state_d;
    ctrl_word_t cw;
    logic [5:0] ring;
    logic       advance;
    logic       load_t1;
    logic       is_alu;
    logic       is_nop;

    sap_contador_anel_6 u_anel (
        .clk_i    (clock),
        .rst_ni   (clear),
        .advance_i(advance),
        .load_t1_i(load_t1),
        .ring_o   (ring)
    );

    assign is_alu = (opcode == OPC_ADD) || (opcode == OPC_SUB);
    assign is_nop = !is_alu && (opcode != OPC_LDA) && (opcode != OPC_OUT) && (opcode != OPC_HLT);

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cw      = '0;
        advance = 1'b0;
        load_t1 = 1'b0;
        if (state_q == StHalted) begin
            cw[CW_HLT] = 1'b1;
        end else begin
            advance = 1'b1;
            unique case (ring)
                TS_T1: begin
                    cw[CW_PC_OUT] = 1'b1;
                    cw[CW_MAR_IN] = 1'b1;
                end
                TS_T2: cw[CW_PC_INC] = 1'b1;
                TS_T3: begin
                    cw[CW_RAM_OUT] = 1'b1;
                    cw[CW_IR_IN]   = 1'b1;
                end
                TS_T4: begin
                    if (is_alu || (opcode == OPC_LDA)) begin
                        cw[CW_IR_OUT] = 1'b1;
                        cw[CW_MAR_IN] = 1'b1;
                    end else if (opcode == OPC_OUT) begin
                        cw[CW_A_OUT]  = 1'b1;
                        cw[CW_OUT_IN] = 1'b1;
                    end else if (opcode == OPC_HLT) begin
                        state_d = StHalted;
                        advance = 1'b0;
                    end
`ifdef SAP_CTRL_CICLO_CURTO_EN
                    if ((opcode == OPC_OUT) || is_nop) begin
                        load_t1 = 1'b1;
                    end
`endif
                end
                TS_T5: begin
                    if (opcode == OPC_LDA) begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_A_IN]    = 1'b1;
`ifdef SAP_CTRL_CICLO_CURTO_EN
                        load_t1 = 1'b1;
`endif
                    end else if (is_alu) begin
                        cw[CW_RAM_OUT] = 1'b1;
                        cw[CW_B_IN]    = 1'b1;
                        cw[CW_SUB]     = (opcode == OPC_SUB);
                    end
                end
                TS_T6: begin
                    if (is_alu) begin
                        cw[CW_ALU_OUT] = 1'b1;
                        cw[CW_A_IN]    = 1'b1;
                        cw[CW_SUB]     = (opcode == OPC_SUB);
                    end
                end
                default: ;
            endcase
        end
        // Reset dominates: nothing reaches the datapath while clear is held low.
        if (!clear) begin
            cw = '0;
        end
    end

    assign t_state = (state_q == StHalted) ? 6'b000000 : ring;

    assign PC_INC  = cw[CW_PC_INC];
    assign PC_OUT  = cw[CW_PC_OUT];
    assign MAR_IN  = cw[CW_MAR_IN];
    assign RAM_OUT = cw[CW_RAM_OUT];
    assign IR_IN   = cw[CW_IR_IN];
    assign IR_OUT  = cw[CW_IR_OUT];
    assign A_IN    = cw[CW_A_IN];
    assign A_OUT   = cw[CW_A_OUT];
    assign B_IN    = cw[CW_B_IN];
    assign ALU_OUT = cw[CW_ALU_OUT];
    assign SUB     = cw[CW_SUB];
    assign OUT_IN  = cw[CW_OUT_IN];
    assign HLT     = cw[CW_HLT];

    a_one_bus_driver: assert property (@(posedge clock) disable iff (!clear)
        $onehot0({PC_OUT, RAM_OUT, IR_OUT, A_OUT, ALU_OUT}));

endmodule

// File: tb/tb_sap_controlador_sequenciador.sv
// Scoreboard bench for sap_controlador_sequenciador: stimulus queues expected words, monitor checks.
module tb_sap_controlador_sequenciador;

    logic       clock;
    logic       clear;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic PC_INC, PC_OUT, MAR_IN, RAM_OUT, IR_IN, IR_OUT;
    logic A_IN, A_OUT, B_IN, ALU_OUT, SUB, OUT_IN, HLT;

    // Bench-side packing of the outputs, MSB first.
    localparam logic [12:0] M_PCI = 13'h1000;
    localparam logic [12:0] M_PCO = 13'h0800;
    localparam logic [12:0] M_MAR = 13'h0400;
    localparam logic [12:0] M_RMO = 13'h0200;
    localparam logic [12:0] M_IRI = 13'h0100;
    localparam logic [12:0] M_IRO = 13'h0080;
    localparam logic [12:0] M_AI  = 13'h0040;
    localparam logic [12:0] M_AO  = 13'h0020;
    localparam logic [12:0] M_BI  = 13'h0010;
    localparam logic [12:0] M_ALU = 13'h0008;
    localparam logic [12:0] M_SUB = 13'h0004;
    localparam logic [12:0] M_OI  = 13'h0002;
    localparam logic [12:0] M_HLT = 13'h0001;

    typedef struct {
        logic [5:0]  t;
        logic [12:0] cw;
        string       name;
    } exp_s;

    exp_s exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    event probe_ev;

    sap_controlador_sequenciador dut (
        .clock  (clock),
        .clear  (clear),
        .opcode (opcode),
        .t_state(t_state),
        .PC_INC (PC_INC),
        .PC_OUT (PC_OUT),
        .MAR_IN (MAR_IN),
        .RAM_OUT(RAM_OUT),
        .IR_IN  (IR_IN),
        .IR_OUT (IR_OUT),
        .A_IN   (A_IN),
        .A_OUT  (A_OUT),
        .B_IN   (B_IN),
        .ALU_OUT(ALU_OUT),
        .SUB    (SUB),
        .OUT_IN (OUT_IN),
        .HLT    (HLT)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) -> probe_ev;

    // Monitor: every probe with a pending expectation is one vector.
    initial begin
        forever begin
            @(probe_ev);
            if (exp_q.size() > 0) begin
                exp_s e;
                logic [12:0] act;
                e   = exp_q.pop_front();
                act = {PC_INC, PC_OUT, MAR_IN, RAM_OUT, IR_IN, IR_OUT, A_IN, A_OUT, B_IN,
                       ALU_OUT, SUB, OUT_IN, HLT};
                n_vec++;
                if (act !== e.cw || t_state !== e.t) begin
                    n_err++;
                    $display("FAIL %s: got t_state=%h ctrl=%h, expected t_state=%h ctrl=%h",
                             e.name, t_state, act, e.t, e.cw);
                end
            end
        end
    end

    task automatic push(input logic [5:0] t, input logic [12:0] cw, input string name);
        exp_s e;
        e.t    = t;
        e.cw   = cw;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // One cycle: drive opcode, queue this cycle's expected outputs, move to the next cycle.
    task automatic cyc(input logic [3:0] opc, input logic [5:0] t, input logic [12:0] cw,
                       input string name);
        opcode = opc;
        push(t, cw, name);
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [3:0] opc);
        cyc(opc, 6'h01, M_PCO | M_MAR, $sformatf("op%h_t1", opc));
        cyc(opc, 6'h02, M_PCI,         $sformatf("op%h_t2", opc));
        cyc(opc, 6'h04, M_RMO | M_IRI, $sformatf("op%h_t3", opc));
    endtask

    task automatic run_instr(input logic [3:0] opc);
        fetch(opc);
        case (opc)
            4'h0: begin
                cyc(opc, 6'h08, M_IRO | M_MAR, "lda_t4");
                cyc(opc, 6'h10, M_RMO | M_AI,  "lda_t5");
`ifndef SAP_CTRL_CICLO_CURTO_EN
                cyc(opc, 6'h20, 13'h0, "lda_t6");
`endif
            end
            4'h1: begin
                cyc(opc, 6'h08, M_IRO | M_MAR, "add_t4");
                cyc(opc, 6'h10, M_RMO | M_BI,  "add_t5");
                cyc(opc, 6'h20, M_ALU | M_AI,  "add_t6");
            end
            4'h2: begin
                cyc(opc, 6'h08, M_IRO | M_MAR,         "sub_t4");
                cyc(opc, 6'h10, M_RMO | M_BI | M_SUB,  "sub_t5");
                cyc(opc, 6'h20, M_ALU | M_AI | M_SUB,  "sub_t6");
            end
            4'hE: begin
                cyc(opc, 6'h08, M_AO | M_OI, "out_t4");
`ifndef SAP_CTRL_CICLO_CURTO_EN
                cyc(opc, 6'h10, 13'h0, "out_t5");
                cyc(opc, 6'h20, 13'h0, "out_t6");
`endif
            end
            4'hF: cyc(opc, 6'h08, 13'h0, "hlt_t4");
            default: begin
                cyc(opc, 6'h08, 13'h0, "nop_t4");
`ifndef SAP_CTRL_CICLO_CURTO_EN
                cyc(opc, 6'h10, 13'h0, "nop_t5");
                cyc(opc, 6'h20, 13'h0, "nop_t6");
`endif
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear  = 1'b0;
        opcode = 4'h0;
        @(posedge clock);
        #1;
        cyc(4'h0, 6'h01, 13'h0, "reset");
        clear = 1'b1;

        run_instr(4'h0);
        run_instr(4'h2);
        run_instr(4'h0);
        run_instr(4'hE);
        run_instr(4'h7);
        run_instr(4'h1);
        run_instr(4'hF);
        for (int i = 0; i < 20; i++) cyc(4'hF, 6'h00, M_HLT, "halted");

        clear = 1'b0;
        cyc(4'hF, 6'h01, 13'h0, "hlt_clear");
        clear = 1'b1;

        // ADD aborted by an asynchronous clear in the middle of T5.
        fetch(4'h1);
        cyc(4'h1, 6'h08, M_IRO | M_MAR, "abort_t4");
        push(6'h10, M_RMO | M_BI, "abort_t5");
        @(negedge clock);
        #2;
        clear = 1'b0;
        #1;
        push(6'h01, 13'h0, "abort_async");
        -> probe_ev;
        @(posedge clock);
        #1;
        cyc(4'h1, 6'h01, 13'h0, "abort_hold");
        clear = 1'b1;

        run_instr(4'h0);
        run_instr(4'h1);
        run_instr(4'hE);
        run_instr(4'hF);
        for (int i = 0; i < 3; i++) cyc(4'hF, 6'h00, M_HLT, "prog_halted");

        @(negedge clock);
        @(negedge clock);
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
